instr_encoder: RTL and testbench

- Sequential RISC-V RV32I instruction encoder. It is the inverse of the control decoder: it takes an instruction id plus register and immediate fields, packs them into a 32-bit instruction word, and writes that word into instruction memory at consecutive addresses.
- Used by the self-test and boot loader path to build programs in IM without an external assembler.
- Checks that each immediate fits its format. Malformed requests are rejected with an error pulse and no write.

---
 rtl/instr_encoder_if.sv | 30 +++
 rtl/instr_encoder.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_instr_encoder.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Request, instruction-memory write and status signals of the RV32I instruction encoder.
// The encoder takes the slave view; the host that issues requests and owns IM takes the master view.
interface instr_encoder_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic [5:0]            req_id;
    logic [4:0]            req_rd;
    logic [4:0]            req_rs1;
    logic [4:0]            req_rs2;
    logic [31:0]           req_imm;
    logic                  im_wr_valid;
    logic                  im_wr_ready;
    logic [ADDR_WIDTH-1:0] im_addr;
    logic [31:0]           im_wdata;
    logic                  err_valid;
    logic [1:0]            err_code;
    logic [15:0]           word_cnt;

    modport master (
        output req_valid, req_id, req_rd, req_rs1, req_rs2, req_imm, im_wr_ready,
        input  req_ready, im_wr_valid, im_addr, im_wdata, err_valid, err_code, word_cnt
    );

    modport slave (
        input  req_valid, req_id, req_rd, req_rs1, req_rs2, req_imm, im_wr_ready,
        output req_ready, im_wr_valid, im_addr, im_wdata, err_valid, err_code, word_cnt
    );
endinterface

// File: rtl/instr_encoder.sv
// Sequential RV32I instruction encoder: packs an instruction id plus register/immediate fields
// into a 32-bit word and writes it to instruction memory at consecutive word addresses.
module instr_encoder #(
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    instr_encoder_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ENC   = 2'b01,
        S_WRITE = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        F_R  = 3'd0,
        F_I  = 3'd1,
        F_SH = 3'd2,
        F_S  = 3'd3,
        F_B  = 3'd4,
        F_J  = 3'd5,
        F_U  = 3'd6
    } fmt_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_RANGE   = 2'b10;
    localparam logic [1:0] ERR_ALIGN   = 2'b11;

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = {{(ADDR_WIDTH-3){1'b0}}, 3'd4};

    state_t                state_r;
    state_t                state_nx_s;
    logic [5:0]            id_r;
    logic [4:0]            rd_r;
    logic [4:0]            rs1_r;
    logic [4:0]            rs2_r;
    logic [31:0]           imm_r;
    logic                  req_ready_r;
    logic                  wr_valid_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [31:0]           wdata_r;
    logic                  err_valid_r;
    logic [1:0]            err_code_r;
    logic [15:0]           word_cnt_r;

    fmt_t                  fmt_s;
    logic [6:0]            opc_s;
    logic [2:0]            f3_s;
    logic [6:0]            f7_s;
    logic                  illegal_s;
    logic                  misalign_s;
    logic                  range_s;
    logic [31:0]           word_s;
    logic [1:0]            code_s;
    logic                  accept_s;

    // Immediate fits a signed field whose top bit is imm[lsb_of_sign]; all higher bits must match it.
    function automatic logic fits_i(input logic [31:0] v);
        return (v[31:11] == 21'h000000) || (v[31:11] == 21'h1FFFFF);
    endfunction

    function automatic logic fits_b(input logic [31:0] v);
        return (v[31:12] == 20'h00000) || (v[31:12] == 20'hFFFFF);
    endfunction

    function automatic logic fits_j(input logic [31:0] v);
        return (v[31:20] == 12'h000) || (v[31:20] == 12'hFFF);
    endfunction

    assign accept_s = bus.req_valid && req_ready_r && (state_r == S_IDLE);

    // Instruction id to format, opcode and function fields.
    always_comb begin
        fmt_s     = F_R;
        opc_s     = OP_R;
        f3_s      = 3'b000;
        f7_s      = F7_ZERO;
        illegal_s = 1'b0;
        case (id_r)
            6'd0:  begin fmt_s = F_R;  f3_s = 3'b000; end
            6'd1:  begin fmt_s = F_R;  f3_s = 3'b000; f7_s = F7_ALT; end
            6'd2:  begin fmt_s = F_R;  f3_s = 3'b111; end
            6'd3:  begin fmt_s = F_R;  f3_s = 3'b110; end
            6'd4:  begin fmt_s = F_R;  f3_s = 3'b100; end
            6'd5:  begin fmt_s = F_R;  f3_s = 3'b001; end
            6'd6:  begin fmt_s = F_R;  f3_s = 3'b101; end
            6'd7:  begin fmt_s = F_R;  f3_s = 3'b101; f7_s = F7_ALT; end
            6'd8:  begin fmt_s = F_R;  f3_s = 3'b010; end
            6'd9:  begin fmt_s = F_R;  f3_s = 3'b011; end
            6'd10: begin fmt_s = F_I;  opc_s = OP_IMM; f3_s = 3'b000; end
            6'd11: begin fmt_s = F_I;  opc_s = OP_IMM; f3_s = 3'b111; end
            6'd12: begin fmt_s = F_I;  opc_s = OP_IMM; f3_s = 3'b110; end
            6'd13: begin fmt_s = F_I;  opc_s = OP_IMM; f3_s = 3'b100; end
            6'd14: begin fmt_s = F_SH; opc_s = OP_IMM; f3_s = 3'b001; end
            6'd15: begin fmt_s = F_SH; opc_s = OP_IMM; f3_s = 3'b101; end
            6'd16: begin fmt_s = F_SH; opc_s = OP_IMM; f3_s = 3'b101; f7_s = F7_ALT; end
            6'd17: begin fmt_s = F_I;  opc_s = OP_IMM; f3_s = 3'b010; end
            6'd18: begin fmt_s = F_I;  opc_s = OP_IMM; f3_s = 3'b011; end
            6'd19: begin fmt_s = F_I;  opc_s = OP_LOAD; f3_s = 3'b000; end
            6'd20: begin fmt_s = F_I;  opc_s = OP_LOAD; f3_s = 3'b100; end
            6'd21: begin fmt_s = F_I;  opc_s = OP_LOAD; f3_s = 3'b001; end
            6'd22: begin fmt_s = F_I;  opc_s = OP_LOAD; f3_s = 3'b101; end
            6'd23: begin fmt_s = F_I;  opc_s = OP_LOAD; f3_s = 3'b010; end
            6'd24: begin fmt_s = F_S;  opc_s = OP_STORE; f3_s = 3'b000; end
            6'd25: begin fmt_s = F_S;  opc_s = OP_STORE; f3_s = 3'b001; end
            6'd26: begin fmt_s = F_S;  opc_s = OP_STORE; f3_s = 3'b010; end
            6'd27: begin fmt_s = F_B;  opc_s = OP_BRANCH; f3_s = 3'b000; end
            6'd28: begin fmt_s = F_B;  opc_s = OP_BRANCH; f3_s = 3'b001; end
            6'd29: begin fmt_s = F_B;  opc_s = OP_BRANCH; f3_s = 3'b100; end
            6'd30: begin fmt_s = F_B;  opc_s = OP_BRANCH; f3_s = 3'b101; end
            6'd31: begin fmt_s = F_B;  opc_s = OP_BRANCH; f3_s = 3'b110; end
            6'd32: begin fmt_s = F_B;  opc_s = OP_BRANCH; f3_s = 3'b111; end
            6'd33: begin fmt_s = F_J;  opc_s = OP_JAL; end
            6'd34: begin fmt_s = F_I;  opc_s = OP_JALR; f3_s = 3'b000; end
            6'd35: begin fmt_s = F_U;  opc_s = OP_LUI; end
            6'd36: begin fmt_s = F_U;  opc_s = OP_AUIPC; end
            default: illegal_s = 1'b1;
        endcase
    end

    // Field packing plus per-format immediate checks; error priority illegal > misaligned > range.
    always_comb begin
        word_s     = 32'h0000_0000;
        misalign_s = 1'b0;
        range_s    = 1'b0;
        case (fmt_s)
            F_R: word_s = {f7_s, rs2_r, rs1_r, f3_s, rd_r, opc_s};
            F_I: begin
                word_s  = {imm_r[11:0], rs1_r, f3_s, rd_r, opc_s};
                range_s = !fits_i(imm_r);
            end
            F_SH: begin
                word_s  = {f7_s, imm_r[4:0], rs1_r, f3_s, rd_r, opc_s};
                range_s = (imm_r[31:5] != 27'h0000000);
            end
            F_S: begin
                word_s  = {imm_r[11:5], rs2_r, rs1_r, f3_s, imm_r[4:0], opc_s};
                range_s = !fits_i(imm_r);
            end
            F_B: begin
                word_s     = {imm_r[12], imm_r[10:5], rs2_r, rs1_r, f3_s,
                              imm_r[4:1], imm_r[11], opc_s};
                misalign_s = imm_r[0];
                range_s    = !fits_b(imm_r);
            end
            F_J: begin
                word_s     = {imm_r[20], imm_r[10:1], imm_r[11], imm_r[19:12], rd_r, opc_s};
                misalign_s = imm_r[0];
                range_s    = !fits_j(imm_r);
            end
            F_U: begin
                word_s     = {imm_r[31:12], rd_r, opc_s};
                misalign_s = (imm_r[11:0] != 12'h000);
            end
            default: word_s = 32'h0000_0000;
        endcase

        if (illegal_s) begin
            code_s = ERR_ILLEGAL;
        end else if (misalign_s) begin
            code_s = ERR_ALIGN;
        end else if (range_s) begin
            code_s = ERR_RANGE;
        end else begin
            code_s = ERR_NONE;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_nx_s = S_ENC;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_ENC: begin
                if (code_s != ERR_NONE) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.im_wr_ready) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_WRITE;
                end
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Request latch, registered outputs, address and word counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_r        <= 6'd0;
            rd_r        <= 5'd0;
            rs1_r       <= 5'd0;
            rs2_r       <= 5'd0;
            imm_r       <= 32'h0000_0000;
            req_ready_r <= 1'b1;
            wr_valid_r  <= 1'b0;
            addr_r      <= BASE_ADDR;
            wdata_r     <= 32'h0000_0000;
            err_valid_r <= 1'b0;
            err_code_r  <= 2'b00;
            word_cnt_r  <= 16'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    err_valid_r <= 1'b0;
                    // clr lands before an accepted request, so that request writes to BASE_ADDR.
                    if (clr) begin
                        addr_r     <= BASE_ADDR;
                        word_cnt_r <= 16'd0;
                    end
                    if (accept_s) begin
                        id_r        <= bus.req_id;
                        rd_r        <= bus.req_rd;
                        rs1_r       <= bus.req_rs1;
                        rs2_r       <= bus.req_rs2;
                        imm_r       <= bus.req_imm;
                        req_ready_r <= 1'b0;
                    end
                end
                S_ENC: begin
                    if (code_s != ERR_NONE) begin
                        err_valid_r <= 1'b1;
                        err_code_r  <= code_s;
                        req_ready_r <= 1'b1;
                    end else begin
                        wdata_r    <= word_s;
                        wr_valid_r <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (bus.im_wr_ready) begin
                        wr_valid_r  <= 1'b0;
                        addr_r      <= addr_r + ADDR_STEP;
                        word_cnt_r  <= word_cnt_r + 16'd1;
                        req_ready_r <= 1'b1;
                    end
                end
                default: begin
                    wr_valid_r  <= 1'b0;
                    err_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_r;
    assign bus.im_wr_valid = wr_valid_r;
    assign bus.im_addr     = addr_r;
    assign bus.im_wdata    = wdata_r;
    assign bus.err_valid   = err_valid_r;
    assign bus.err_code    = err_code_r;
    assign bus.word_cnt    = word_cnt_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-assembled RV32I words, immediate checks, stalls,
// reset abort, clear and address wrap.
module tb_instr_encoder;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst;
    logic clr;

    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_WIDTH(AW)) bus ();

    instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(10'h000)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] addr_m;
    logic [15:0]   cnt_m;
    logic [31:0]   wdata_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, " wr_valid"},  32'(bus.im_wr_valid), 32'd0);
        check({tag, " addr"},      32'(bus.im_addr), 32'd0);
        check({tag, " wdata"},     bus.im_wdata, 32'h0000_0000);
        check({tag, " err_valid"}, 32'(bus.err_valid), 32'd0);
        check({tag, " err_code"},  32'(bus.err_code), 32'd0);
        check({tag, " word_cnt"},  32'(bus.word_cnt), 32'd0);
    endtask

    // Waits (bounded) for req_ready, presents one request for a single accepted cycle.
    task automatic send(input logic [5:0] id, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input logic c);
        int n = 0;
        while (!bus.req_ready && n < 10) begin
            tick();
            n++;
        end
        check("req_ready_wait", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_id    = id;
        bus.req_rd    = rd;
        bus.req_rs1   = rs1;
        bus.req_rs2   = rs2;
        bus.req_imm   = imm;
        clr           = c;
        tick();
        bus.req_valid = 1'b0;
        clr           = 1'b0;
        bus.req_id    = 6'd63;
        bus.req_rd    = 5'd31;
        bus.req_rs1   = 5'd31;
        bus.req_rs2   = 5'd31;
        bus.req_imm   = 32'hFFFF_FFFF;
    endtask

    task automatic do_write(input string tag, input logic [5:0] id, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] imm, input logic c, input logic [31:0] exp_word);
        if (c) begin
            addr_m = 10'h000;
            cnt_m  = 16'd0;
        end
        send(id, rd, rs1, rs2, imm, c);
        check({tag, " enc_valid"}, 32'(bus.im_wr_valid), 32'd0);
        check({tag, " enc_ready"}, 32'(bus.req_ready), 32'd0);
        tick();
        check({tag, " wr_valid"}, 32'(bus.im_wr_valid), 32'd1);
        check({tag, " wdata"}, bus.im_wdata, exp_word);
        check({tag, " addr"}, 32'(bus.im_addr), 32'(addr_m));
        tick();
        addr_m  = addr_m + 10'd4;
        cnt_m   = cnt_m + 16'd1;
        wdata_m = exp_word;
        check({tag, " done_valid"}, 32'(bus.im_wr_valid), 32'd0);
        check({tag, " next_addr"}, 32'(bus.im_addr), 32'(addr_m));
        check({tag, " word_cnt"}, 32'(bus.word_cnt), 32'(cnt_m));
    endtask

    task automatic do_err(input string tag, input logic [5:0] id, input logic [31:0] imm,
                          input logic [1:0] exp_code);
        send(id, 5'd1, 5'd2, 5'd3, imm, 1'b0);
        check({tag, " pre_err"}, 32'(bus.err_valid), 32'd0);
        tick();
        check({tag, " err_valid"}, 32'(bus.err_valid), 32'd1);
        check({tag, " err_code"}, 32'(bus.err_code), 32'(exp_code));
        check({tag, " no_write"}, 32'(bus.im_wr_valid), 32'd0);
        check({tag, " wdata_kept"}, bus.im_wdata, wdata_m);
        tick();
        check({tag, " err_pulse"}, 32'(bus.err_valid), 32'd0);
        check({tag, " addr_kept"}, 32'(bus.im_addr), 32'(addr_m));
        check({tag, " cnt_kept"}, 32'(bus.word_cnt), 32'(cnt_m));
        check({tag, " ready_back"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        rst             = 1'b1;
        clr             = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_id      = 6'd0;
        bus.req_rd      = 5'd0;
        bus.req_rs1     = 5'd0;
        bus.req_rs2     = 5'd0;
        bus.req_imm     = 32'h0000_0000;
        bus.im_wr_ready = 1'b1;
        addr_m          = 10'h000;
        cnt_m           = 16'd0;
        wdata_m         = 32'h0000_0000;

        repeat (2) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Basic encodings; unused register fields are given non-zero junk.
        do_write("add",   6'd0,  5'd3, 5'd1, 5'd2, 32'h0000_0000, 1'b0, 32'h002081B3);
        do_write("addi",  6'd10, 5'd1, 5'd0, 5'd9, 32'h0000_0005, 1'b0, 32'h00500093);
        do_write("sw",    6'd26, 5'd7, 5'd1, 5'd2, 32'h0000_0008, 1'b0, 32'h0020A423);
        do_write("srai",  6'd16, 5'd1, 5'd1, 5'd9, 32'h0000_0003, 1'b0, 32'h4030D093);
        do_write("beq",   6'd27, 5'd5, 5'd1, 5'd2, 32'hFFFF_FFF8, 1'b0, 32'hFE208CE3);
        do_write("jal",   6'd33, 5'd1, 5'd4, 5'd6, 32'h0000_0800, 1'b0, 32'h001000EF);
        do_write("lui",   6'd35, 5'd5, 5'd7, 5'd8, 32'h1234_5000, 1'b0, 32'h123452B7);
        do_write("sub",   6'd1,  5'd3, 5'd1, 5'd2, 32'h0000_0000, 1'b0, 32'h402081B3);
        do_write("lw",    6'd23, 5'd5, 5'd6, 5'd9, 32'hFFFF_FFFC, 1'b0, 32'hFFC32283);
        do_write("jalr",  6'd34, 5'd1, 5'd2, 5'd9, 32'h0000_0004, 1'b0, 32'h004100E7);
        do_write("auipc", 6'd36, 5'd1, 5'd3, 5'd3, 32'h0000_1000, 1'b0, 32'h00001097);
        do_write("addi_max", 6'd10, 5'd1, 5'd0, 5'd0, 32'h0000_07FF, 1'b0, 32'h7FF00093);
        do_write("addi_min", 6'd10, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 1'b0, 32'h80000093);
        do_write("beq_max",  6'd27, 5'd0, 5'd0, 5'd0, 32'h0000_0FFE, 1'b0, 32'h7E000FE3);

        // Rejected requests.
        do_err("addi_4096",   6'd10, 32'h0000_1000, 2'b10);
        do_err("beq_odd",     6'd27, 32'h0000_0003, 2'b11);
        do_err("id_50",       6'd50, 32'h0000_0000, 2'b01);
        do_err("srli_32",     6'd15, 32'h0000_0020, 2'b10);
        do_err("lui_low",     6'd35, 32'h1234_5001, 2'b11);
        do_err("beq_4096",    6'd27, 32'h0000_1000, 2'b10);
        do_err("beq_odd_far", 6'd27, 32'h0000_1001, 2'b11);
        do_err("id_37_odd",   6'd37, 32'h0000_0001, 2'b01);

        // IM back-pressure.
        bus.im_wr_ready = 1'b0;
        send(6'd0, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(bus.im_wr_valid), 32'd1);
            check("stall_addr", 32'(bus.im_addr), 32'(addr_m));
            check("stall_wdata", bus.im_wdata, 32'h002081B3);
            check("stall_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.im_wr_ready = 1'b1;
        tick();
        addr_m  = addr_m + 10'd4;
        cnt_m   = cnt_m + 16'd1;
        wdata_m = 32'h002081B3;
        check("stall_release_addr", 32'(bus.im_addr), 32'(addr_m));
        check("stall_release_valid", 32'(bus.im_wr_valid), 32'd0);
        check("stall_release_cnt", 32'(bus.word_cnt), 32'(cnt_m));

        // Asynchronous reset in the middle of a write.
        bus.im_wr_ready = 1'b0;
        send(6'd4, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 1'b0);
        tick();
        check("pre_abort_valid", 32'(bus.im_wr_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        tick();
        rst             = 1'b0;
        bus.im_wr_ready = 1'b1;
        addr_m          = 10'h000;
        cnt_m           = 16'd0;
        wdata_m         = 32'h0000_0000;
        tick();

        // Clear in idle after three writes.
        do_write("w0", 6'd2, 5'd1, 5'd2, 5'd3, 32'h0000_0000, 1'b0, 32'h003170B3);
        do_write("w1", 6'd3, 5'd1, 5'd2, 5'd3, 32'h0000_0000, 1'b0, 32'h003160B3);
        do_write("w2", 6'd4, 5'd1, 5'd2, 5'd3, 32'h0000_0000, 1'b0, 32'h003140B3);
        clr = 1'b1;
        tick();
        clr    = 1'b0;
        addr_m = 10'h000;
        cnt_m  = 16'd0;
        check("clr_addr", 32'(bus.im_addr), 32'd0);
        check("clr_cnt", 32'(bus.word_cnt), 32'd0);

        // Fill the whole address space once; the last write is at 1020 and the address wraps to 0.
        for (int i = 0; i < 256; i++) begin
            do_write("fill", 6'd0, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 1'b0, 32'h002081B3);
        end
        check("wrap_addr", 32'(bus.im_addr), 32'd0);
        check("wrap_cnt", 32'(bus.word_cnt), 32'd256);

        // Clear arriving together with an accepted request.
        do_write("pre_clr", 6'd0, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 1'b0, 32'h002081B3);
        do_write("clr_req", 6'd10, 5'd1, 5'd0, 5'd0, 32'h0000_0005, 1'b1, 32'h00500093);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
